// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sysid_checker
//  Purpose  : Boot-time consumer of the system-ID slave. After reset (or on a
//             start pulse from a finished state) it issues two Avalon-MM reads:
//             address 0 (ID word) and address 1 (build timestamp). It compares
//             them against the expected values, retrying whole read passes on
//             mismatch, and latches a pass/fail verdict.
//
//  Ports    : clock        in   system clock
//             reset_n      in   asynchronous active-low reset
//             start        in   single-cycle pulse, re-runs check from PASS/FAIL
//             address      out  read address to sysid slave
//             read         out  read strobe to sysid slave
//             readdata     in   [31:0] data from sysid slave
//             busy         out  check in progress (low only in PASS/FAIL)
//             id_ok        out  latched pass
//             id_fail      out  latched fail
//             id_value     out  [31:0] last captured address-0 word
//             ts_value     out  [31:0] last captured address-1 word
//             retry_count  out  [3:0] retries consumed in current/last run
//
//  Revision : 1.0  initial release
// ============================================================================
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID   = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS   = 32'h53A09A30,
    parameter int          CHECK_TS      = 1,
    parameter int          READ_LATENCY  = 1,
    parameter int          STARTUP_DELAY = 16,
    parameter int          MAX_RETRIES   = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        id_ok,
    output logic        id_fail,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    localparam logic [2:0] c_read_latency  = 3'(READ_LATENCY);
    localparam logic [7:0] c_startup_delay = 8'(STARTUP_DELAY);
    localparam logic [3:0] c_max_retries   = 4'(MAX_RETRIES);
    localparam logic       c_check_ts      = (CHECK_TS != 0);

    typedef enum logic [2:0] {
        S_DELAY = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_EVAL  = 3'd3,
        S_PASS  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_delay_cnt;
    logic [2:0]  r_lat_cnt;
    logic        r_address;
    logic        r_read;
    logic        r_busy;
    logic        r_id_ok;
    logic        r_id_fail;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic [3:0]  r_retry_count;

    logic        w_match;

    // Evaluated only from captured registers, so readdata never reaches an
    // output combinationally.
    assign w_match = (r_id_value == EXPECTED_ID) &&
                     (!c_check_ts || (r_ts_value == EXPECTED_TS));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_DELAY;
            r_delay_cnt   <= 8'd0;
            r_lat_cnt     <= 3'd0;
            r_address     <= 1'b0;
            r_read        <= 1'b0;
            r_busy        <= 1'b1;
            r_id_ok       <= 1'b0;
            r_id_fail     <= 1'b0;
            r_id_value    <= 32'd0;
            r_ts_value    <= 32'd0;
            r_retry_count <= 4'd0;
        end else begin
            case (r_state)
                S_DELAY: begin
                    // The ID read is launched on the exit edge so the strobe
                    // is already up during the first RD_ID cycle.
                    if (r_delay_cnt == c_startup_delay) begin
                        r_state   <= S_RD_ID;
                        r_address <= 1'b0;
                        r_read    <= 1'b1;
                        r_lat_cnt <= 3'd0;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + 8'd1;
                    end
                end

                S_RD_ID: begin
                    if (r_lat_cnt == c_read_latency) begin
                        r_id_value <= readdata;
                        r_read     <= 1'b0;
                        r_lat_cnt  <= 3'd0;
                        r_state    <= S_RD_TS;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end

                S_RD_TS: begin
                    // First cycle here is the mandatory idle gap between the
                    // two strobes; the timestamp read is launched from it.
                    if (!r_read) begin
                        r_address <= 1'b1;
                        r_read    <= 1'b1;
                        r_lat_cnt <= 3'd0;
                    end else if (r_lat_cnt == c_read_latency) begin
                        r_ts_value <= readdata;
                        r_read     <= 1'b0;
                        r_address  <= 1'b0;
                        r_lat_cnt  <= 3'd0;
                        r_state    <= S_EVAL;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end

                S_EVAL: begin
                    if (w_match) begin
                        r_state   <= S_PASS;
                        r_id_ok   <= 1'b1;
                        r_id_fail <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (r_retry_count < c_max_retries) begin
                        r_retry_count <= r_retry_count + 4'd1;
                        r_state       <= S_RD_ID;
                        r_address     <= 1'b0;
                        r_read        <= 1'b1;
                        r_lat_cnt     <= 3'd0;
                    end else begin
                        r_state   <= S_FAIL;
                        r_id_fail <= 1'b1;
                        r_id_ok   <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end

                S_PASS, S_FAIL: begin
                    // Re-run skips the startup delay: the slave is known alive.
                    if (start) begin
                        r_id_ok       <= 1'b0;
                        r_id_fail     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_retry_count <= 4'd0;
                        r_state       <= S_RD_ID;
                        r_address     <= 1'b0;
                        r_read        <= 1'b1;
                        r_lat_cnt     <= 3'd0;
                    end
                end

                default: begin
                    r_state <= S_DELAY;
                end
            endcase
        end
    end

    assign address     = r_address;
    assign read        = r_read;
    assign busy        = r_busy;
    assign id_ok       = r_id_ok;
    assign id_fail     = r_id_fail;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign retry_count = r_retry_count;

endmodule
`default_nettype wire

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Consumer stage sitting directly downstream of the system-ID slave; acts as its Avalon-MM read master.
- After reset it reads the ID word at address 0 and the build timestamp at address 1, compares both against expected values, and latches pass/fail status.
- Status gates boot-time logic (e.g. holds bridges/peripherals in reset) and is exported for software/debug.

Parameters:
- EXPECTED_ID, 32'hACD51302, expected word at address 0
- EXPECTED_TS, 32'h53A09A30, expected word at address 1
- CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp captured only
- READ_LATENCY, 1, cycles from address/read assertion to readdata sample (1..7)
- STARTUP_DELAY, 16, cycles after reset release before first read (0..255)
- MAX_RETRIES, 3, extra full read passes after a mismatch before FAIL (0..15)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; re-runs the check from DONE states
- address  out  1  read address to sysid slave
- read  out  1  read strobe to sysid slave
- readdata  in  32  data from sysid slave
- busy  out  1  check in progress
- id_ok  out  1  latched pass
- id_fail  out  1  latched fail
- id_value  out  32  last captured address-0 word
- ts_value  out  32  last captured address-1 word
- retry_count  out  4  retries consumed in current/last run

Behaviour:
- Reset (async, reset_n low): state=DELAY, delay counter=0, address=0, read=0, busy=1, id_ok=0, id_fail=0, id_value=0, ts_value=0, retry_count=0.
- All outputs registered; no combinational path readdata->outputs.
- States: DELAY, RD_ID, RD_TS, EVAL, PASS, FAIL.
- DELAY: count to STARTUP_DELAY (0 = exit after one cycle) -> RD_ID.
- RD_ID: drive address=0, read=1; latency counter from 0; on count==READ_LATENCY capture readdata into id_value, deassert read -> RD_TS.
- RD_TS: same with address=1, capture into ts_value -> EVAL. At least one cycle with read=0 between the two reads.
- EVAL (1 cycle): match = (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS).
  - match -> PASS.
  - mismatch and retry_count<MAX_RETRIES -> retry_count+1, -> RD_ID.
  - mismatch and retry_count==MAX_RETRIES -> FAIL.
- PASS: id_ok=1, id_fail=0, busy=0. FAIL: id_fail=1, id_ok=0, busy=0. Both hold until start or reset.
- start in PASS/FAIL: next cycle id_ok=0, id_fail=0, busy=1, retry_count=0 -> RD_ID (no startup delay).
- start in any other state: ignored.
- id_ok and id_fail never both 1. busy=0 only in PASS/FAIL.
- Reset mid-read: read drops immediately (async); sequence restarts from DELAY after release.
- Latency from reset release to PASS, no retries: STARTUP_DELAY + 2*(READ_LATENCY+1) + 2 cycles, ±1; the bench checks within that window.

Test Plan:
- Slave returns 32'hACD51302/32'h53A09A30 with defaults -> two reads (address 0 then 1), id_ok=1, id_fail=0, retry_count=0, busy=0 within the latency window.
- Address-0 word 32'hDEADBEEF permanently -> exactly 4 read passes (8 read strobes), retry_count=3, id_fail=1, id_value=32'hDEADBEEF.
- Wrong ID on first pass only, correct afterwards -> id_ok=1, retry_count=1.
- CHECK_TS=0, timestamp 32'h00000000 -> id_ok=1, ts_value=0. CHECK_TS=1 with the same stimulus -> id_fail=1.
- In PASS, change slave ID to a wrong value and pulse start -> id_ok clears the next cycle, busy=1, then id_fail=1 after retries. start pulsed during RD_ID is ignored.
- Assert reset_n low mid-RD_TS -> read=0 and all status cleared immediately; after release, rerun completes with id_ok=1. Repeat with READ_LATENCY=3 and verify sampling on the third cycle.
